// File: rtl/tlb_pkg.sv
// Shared definitions for the CP0-side TLB instruction sequencer: op encodings,
// tlb_config / TLB entry field offsets and the FSM state type.
package tlb_pkg;

  localparam int TLB_ENTRIES_DEF = 16;
  localparam int IDX_W_DEF       = 4;

  // op_code encodings
  localparam logic [1:0] TLB_OP_TLBR  = 2'd0;
  localparam logic [1:0] TLB_OP_TLBWI = 2'd1;
  localparam logic [1:0] TLB_OP_TLBWR = 2'd2;
  localparam logic [1:0] TLB_OP_TLBP  = 2'd3;

  // Entry layout (80 bits) is tlb_config without the trailing IDX field
  localparam int TLB_ENTRY_W  = 80;
  localparam int TLB_CONFIG_W = 84;

  localparam int ENT_ASID_LSB = 72;
  localparam int ENT_G_BIT    = 71;
  localparam int ENT_VPN2_LSB = 52;
  localparam int ENT_PFN1_LSB = 28;
  localparam int ENT_D1_BIT   = 27;
  localparam int ENT_V1_BIT   = 26;
  localparam int ENT_PFN0_LSB = 2;
  localparam int ENT_D0_BIT   = 1;
  localparam int ENT_V0_BIT   = 0;

  // Same fields inside tlb_config, shifted up by the IDX field
  localparam int CFG_IDX_LSB  = 0;
  localparam int CFG_ASID_LSB = ENT_ASID_LSB + 4;
  localparam int CFG_G_BIT    = ENT_G_BIT + 4;
  localparam int CFG_VPN2_LSB = ENT_VPN2_LSB + 4;

  localparam int ASID_W = 8;
  localparam int VPN2_W = 19;
  localparam int PFN_W  = 24;

  localparam int TLBP_MISS_BIT = 31;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_PROBE    = 3'd2,
    ST_PROBE_WB = 3'd3,
    ST_READ     = 3'd4,
    ST_READ_WB  = 3'd5
  } tlb_state_e;

  // Rebuild a CP0 EntryLo word; the cache attribute field reads back as zero
  function automatic logic [31:0] make_entrylo(input logic [PFN_W-1:0] pfn,
                                               input logic d, input logic v,
                                               input logic g);
    make_entrylo = {6'b0, pfn, 3'b0, d, v, g};
  endfunction

endpackage

// File: rtl/tlb_random_reg.sv
// CP0 Random register: free-running down-counter that wraps to the top entry
// when it reaches Wired (or zero), and restarts at the top when Wired is written.
module tlb_random_reg #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] wired_i,
  input  logic             wired_we_i,
  output logic [IDX_W-1:0] random_o
);

  localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

  logic [IDX_W-1:0] random_q;
  logic [IDX_W-1:0] random_d;

  // Next value: Wired write wins, then wrap at Wired/zero, else count down
  always_comb begin
    random_d = random_q - IDX_W'(1);
    if (wired_we_i || (random_q == wired_i) || (random_q == '0)) begin
      random_d = RAND_TOP;
    end
  end

  // Counter register, keeps running while TLB ops are in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) random_q <= RAND_TOP;
    else     random_q <= random_d;
  end

  assign random_o = random_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB instruction sequencer (TLBR/TLBWI/TLBWR/TLBP) between CP0 and the TLB.
// Snapshots CP0 state into tlb_config, strobes the TLB, and writes probe/read
// results back into CP0 Index / EntryHi / EntryLo0 / EntryLo1.
//
// Request handshake: a request is taken on a rising edge where op_valid and
// op_ready are both high. op_ready is high only in IDLE, so op_valid held
// across an op (including the op_done cycle) is simply re-sampled once the
// FSM is back in IDLE. op_done pulses for one cycle when the op retires.
module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = TLB_ENTRIES_DEF,
  parameter int IDX_W       = IDX_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        op_valid,
  input  logic [1:0]                  op_code,
  output logic                        op_ready,
  output logic                        op_done,
  input  logic [IDX_W-1:0]            cp0_index,
  input  logic [IDX_W-1:0]            cp0_wired,
  input  logic                        cp0_wired_we,
  input  logic [31:0]                 cp0_entryhi,
  input  logic [31:0]                 cp0_entrylo0,
  input  logic [31:0]                 cp0_entrylo1,
  output logic [TLB_ENTRY_W+IDX_W-1:0] tlb_config,
  output logic                        tlbwi,
  output logic                        tlbp,
  input  logic [31:0]                 tlbp_result,
  output logic [IDX_W-1:0]            tlb_rd_index,
  input  logic [TLB_ENTRY_W-1:0]      tlb_rd_entry,
  output logic [IDX_W-1:0]            random,
  output logic                        index_we,
  output logic [31:0]                 index_wdata,
  output logic                        entry_we,
  output logic [31:0]                 entryhi_wdata,
  output logic [31:0]                 entrylo0_wdata,
  output logic [31:0]                 entrylo1_wdata,
  output tlb_state_e                  dbg_state
);

  localparam int CFG_W = TLB_ENTRY_W + IDX_W;

  tlb_state_e          state_q;
  logic                op_ready_q, op_done_q, tlbwi_q, tlbp_q;
  logic                index_we_q, entry_we_q;
  logic [CFG_W-1:0]    cfg_q;
  logic [IDX_W-1:0]    rd_index_q;
  logic [31:0]         index_wdata_q;
  logic [31:0]         entryhi_q, entrylo0_q, entrylo1_q;

  logic [IDX_W-1:0]    random_val;
  logic [IDX_W-1:0]    snap_idx;
  logic [CFG_W-1:0]    cfg_d;
  logic [31:0]         index_wdata_d;
  logic [31:0]         entryhi_d, entrylo0_d, entrylo1_d;
  logic                accept;

  tlb_random_reg #(
    .TLB_ENTRIES (TLB_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_random (
    .clk        (clk),
    .rst        (rst),
    .wired_i    (cp0_wired),
    .wired_we_i (cp0_wired_we),
    .random_o   (random_val)
  );

  assign accept = op_valid && op_ready_q;

  // Pack the CP0 snapshot; TLBWR targets the Random value of the accept cycle
  always_comb begin
    snap_idx = (op_code == TLB_OP_TLBWR) ? random_val : cp0_index;
    cfg_d = {cp0_entryhi[7:0],
             cp0_entrylo0[0] & cp0_entrylo1[0],
             cp0_entryhi[31:13],
             cp0_entrylo1[29:6], cp0_entrylo1[2], cp0_entrylo1[1],
             cp0_entrylo0[29:6], cp0_entrylo0[2], cp0_entrylo0[1],
             snap_idx};
  end

  // Unpack probe result and read entry into CP0 writeback words
  always_comb begin
    index_wdata_d = {{(32-IDX_W){1'b0}}, tlbp_result[IDX_W-1:0]};
    if (tlbp_result[TLBP_MISS_BIT]) index_wdata_d = 32'h8000_0000;
    entryhi_d  = {tlb_rd_entry[ENT_VPN2_LSB +: VPN2_W], 5'b0,
                  tlb_rd_entry[ENT_ASID_LSB +: ASID_W]};
    entrylo0_d = make_entrylo(tlb_rd_entry[ENT_PFN0_LSB +: PFN_W],
                              tlb_rd_entry[ENT_D0_BIT], tlb_rd_entry[ENT_V0_BIT],
                              tlb_rd_entry[ENT_G_BIT]);
    entrylo1_d = make_entrylo(tlb_rd_entry[ENT_PFN1_LSB +: PFN_W],
                              tlb_rd_entry[ENT_D1_BIT], tlb_rd_entry[ENT_V1_BIT],
                              tlb_rd_entry[ENT_G_BIT]);
  end

  // Sequencer FSM with registered strobes; pulses default low every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_ready_q    <= 1'b1;
      op_done_q     <= 1'b0;
      tlbwi_q       <= 1'b0;
      tlbp_q        <= 1'b0;
      index_we_q    <= 1'b0;
      entry_we_q    <= 1'b0;
      cfg_q         <= '0;
      rd_index_q    <= '0;
      index_wdata_q <= '0;
      entryhi_q     <= '0;
      entrylo0_q    <= '0;
      entrylo1_q    <= '0;
    end else begin
      op_done_q  <= 1'b0;
      tlbwi_q    <= 1'b0;
      tlbp_q     <= 1'b0;
      index_we_q <= 1'b0;
      entry_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cfg_q      <= cfg_d;
            op_ready_q <= 1'b0;
            if (op_code == TLB_OP_TLBR) begin
              rd_index_q <= cp0_index;
              state_q    <= ST_READ;
            end else if (op_code == TLB_OP_TLBP) begin
              tlbp_q  <= 1'b1;
              state_q <= ST_PROBE;
            end else begin
              tlbwi_q   <= 1'b1;
              op_done_q <= 1'b1;
              state_q   <= ST_WRITE;
            end
          end
        end
        ST_PROBE: begin
          index_we_q    <= 1'b1;
          op_done_q     <= 1'b1;
          index_wdata_q <= index_wdata_d;
          state_q       <= ST_PROBE_WB;
        end
        ST_READ: begin
          entry_we_q <= 1'b1;
          op_done_q  <= 1'b1;
          entryhi_q  <= entryhi_d;
          entrylo0_q <= entrylo0_d;
          entrylo1_q <= entrylo1_d;
          state_q    <= ST_READ_WB;
        end
        default: begin
          op_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign op_ready       = op_ready_q;
  assign op_done        = op_done_q;
  assign tlbwi          = tlbwi_q;
  assign tlbp           = tlbp_q;
  assign tlb_config     = cfg_q;
  assign tlb_rd_index   = rd_index_q;
  assign random         = random_val;
  assign index_we       = index_we_q;
  assign index_wdata    = index_wdata_q;
  assign entry_we       = entry_we_q;
  assign entryhi_wdata  = entryhi_q;
  assign entrylo0_wdata = entrylo0_q;
  assign entrylo1_wdata = entrylo1_q;
  assign dbg_state      = state_q;

  // CP0 bits that carry no TLB meaning (cache attr, reserved, probe padding)
  logic unused_bits;
  assign unused_bits = ^{cp0_entryhi[12:8], cp0_entrylo0[31:30], cp0_entrylo0[5:3],
                         cp0_entrylo1[31:30], cp0_entrylo1[5:3],
                         tlbp_result[30:IDX_W]};

endmodule
